// File: rtl/rc_gearbox256_if.sv
// RC gearbox stream interfaces: the PCIe RC AXI-S beat side
// and the realigned descriptor + payload side.
interface rc_axis_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 75
);
  logic [DATA_WIDTH-1:0]    tdata;
  logic                     tvalid;
  logic                     tlast;
  logic [DATA_WIDTH/32-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tready;

  modport master (
    output tdata, tvalid, tlast, tkeep, tuser,
    input  tready
  );
  modport slave (
    input  tdata, tvalid, tlast, tkeep, tuser,
    output tready
  );
endinterface

interface rc_out_if #(
  parameter int DATA_WIDTH = 256
);
  logic [95:0]              descriptor;
  logic [DATA_WIDTH-1:0]    payload;
  logic [10:0]              dw_count;
  logic [DATA_WIDTH/32-1:0] keep;
  logic                     sop;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport master (
    output descriptor, payload, dw_count,
    output keep, sop, last, valid,
    input  ready
  );
  modport slave (
    input  descriptor, payload, dw_count,
    input  keep, sop, last, valid,
    output ready
  );
endinterface

// File: rtl/rc_gearbox256.sv
// RC realigner: 3-DW descriptor + DW3-offset payload -> DW0-aligned beats.
// RC_GEARBOX_ERR_CHECK_EN adds rc_err_pulse/rc_err_count protocol checks.
module rc_gearbox256 #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 75
) (
  input  logic        clk,
  input  logic        rst_n,
  rc_axis_if.slave    rx,
  rc_out_if.master    tx
`ifdef RC_GEARBOX_ERR_CHECK_EN
  ,
  output logic        rc_err_pulse,
  output logic [15:0] rc_err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    FLUSH
  } state_t;

  state_t state_q, state_n;

  logic [159:0]           saver_q;
  logic [95:0]            desc_q;
  logic [10:0]            n_q;
  logic                   sop_pend_q;
  logic                   valid_q;
  logic                   sop_q;
  logic                   last_q;
  logic [7:0]             keep_q;
  logic [DATA_WIDTH-1:0]  pay_q;

  logic [TUSER_WIDTH-1:0] user;
  logic                   sof;
  logic                   adv;
  logic                   acc;
  logic                   restart;
  logic                   tail_fit;
  logic [10:0]            n_in;
  logic [10:0]            r;

  logic                   emit;
  logic                   sop_n;
  logic                   last_n;
  logic [7:0]             keep_n;
  logic [DATA_WIDTH-1:0]  pay_n;

  logic                   unused_bits;

  function automatic logic [7:0] keep_of(
    input logic [10:0] n
  );
    if (n >= 11'd8) return 8'hFF;
    return 8'((9'd1 << n[2:0]) - 9'd1);
  endfunction

  assign user = rx.tuser;
  assign sof  = user[32];
  assign n_in = rx.tdata[42:32];
  assign r    = (n_q[2:0] == 3'd0) ? 11'd8
              : {8'd0, n_q[2:0]};
  assign tail_fit = r >= 11'd6;
  assign adv  = !valid_q || tx.ready;

  assign unused_bits = ^{rx.tkeep,
                         user[TUSER_WIDTH-1:33],
                         user[31:0]};

`ifdef RC_GEARBOX_ERR_CHECK_EN
  // A fresh SOP inside a TLP is held off until the old TLP is closed.
  assign restart = state_q == BODY && rx.tvalid && sof;
`else
  assign restart = 1'b0;
`endif

  assign rx.tready = rst_n && adv
                  && state_q != FLUSH && !restart;
  assign acc = rx.tvalid && rx.tready;

  assign tx.valid      = valid_q;
  assign tx.payload    = pay_q;
  assign tx.keep       = keep_q;
  assign tx.sop        = sop_q;
  assign tx.last       = last_q;
  assign tx.descriptor = desc_q;
  assign tx.dw_count   = n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc && sof && n_in != 11'd0 && !rx.tlast)
          state_n = BODY;
      end
      BODY: begin
        if (restart && adv)
          state_n = IDLE;
        else if (acc && rx.tlast)
          state_n = tail_fit ? IDLE : FLUSH;
      end
      FLUSH: begin
        if (adv) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    emit   = 1'b0;
    sop_n  = 1'b0;
    last_n = 1'b0;
    keep_n = 8'h00;
    pay_n  = '0;
    unique case (state_q)
      IDLE: begin
        if (acc && sof && n_in == 11'd0) begin
          emit   = 1'b1;
          sop_n  = 1'b1;
          last_n = 1'b1;
        end else if (acc && sof && rx.tlast) begin
          emit   = 1'b1;
          sop_n  = 1'b1;
          last_n = 1'b1;
          keep_n = keep_of(n_in);
          pay_n  = {96'd0, rx.tdata[255:96]};
        end
      end
      BODY: begin
        if (restart && adv) begin
          emit   = 1'b1;
          sop_n  = sop_pend_q;
          last_n = 1'b1;
        end else if (acc) begin
          emit   = 1'b1;
          sop_n  = sop_pend_q;
          last_n = rx.tlast && tail_fit;
          keep_n = last_n ? keep_of(r) : 8'hFF;
          pay_n  = {rx.tdata[95:0], saver_q};
        end
      end
      FLUSH: begin
        if (adv) begin
          emit   = 1'b1;
          last_n = 1'b1;
          keep_n = keep_of(r);
          pay_n  = {96'd0, saver_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pay_q      <= '0;
      keep_q     <= 8'h00;
      sop_q      <= 1'b0;
      last_q     <= 1'b0;
      desc_q     <= '0;
      n_q        <= '0;
      saver_q    <= '0;
      sop_pend_q <= 1'b0;
    end else begin
      if (adv) begin
        valid_q <= emit;
        if (emit) begin
          pay_q  <= pay_n;
          keep_q <= keep_n;
          sop_q  <= sop_n;
          last_q <= last_n;
        end
      end
      if (acc && state_q == IDLE && sof) begin
        desc_q     <= rx.tdata[95:0];
        n_q        <= n_in;
        saver_q    <= rx.tdata[255:96];
        sop_pend_q <= 1'b1;
      end else if (acc && state_q == BODY) begin
        saver_q    <= rx.tdata[255:96];
        sop_pend_q <= 1'b0;
      end
    end
  end

`ifdef RC_GEARBOX_ERR_CHECK_EN
  logic [11:0] beat_q;
  logic [11:0] exp_in;
  logic [11:0] exp_q;
  logic        err_ev;

  // Expected input beat count is ceil((N + 3) / 8).
  assign exp_in = 12'(({1'b0, n_in} + 12'd10) >> 3);
  assign exp_q  = 12'(({1'b0, n_q} + 12'd10) >> 3);

  assign err_ev =
      (state_q == IDLE && acc && !sof)
   || (state_q == IDLE && acc && sof
       && rx.tlast && exp_in != 12'd1)
   || (state_q == BODY && acc && rx.tlast
       && beat_q + 12'd1 != exp_q)
   || (restart && adv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q       <= '0;
      rc_err_pulse <= 1'b0;
      rc_err_count <= '0;
    end else begin
      if (acc && state_q == IDLE && sof)
        beat_q <= 12'd1;
      else if (acc && state_q == BODY)
        beat_q <= beat_q + 12'd1;
      rc_err_pulse <= err_ev;
      if (err_ev && rc_err_count != 16'hFFFF)
        rc_err_count <= rc_err_count + 16'd1;
    end
  end
`endif

endmodule
